emif_byte_master: RTL and testbench

Bus initiator for the 8-bit external memory interface (EMIF) that the Ethernet MAC exposes as a responder. It accepts 1–4 byte read/write commands from an application-side command port and serialises them into individual EMIF byte cycles, each completed by `memack`. It returns read data, an error status on timeout, and a rising-edge event for the responder's `irq`. It sits in the `clk_app_i` domain between the application/CPU logic and the MAC's EMIF slave port.

---
 rtl/emif_byte_master.sv | 161 ++++++++++++++++
 tb/tb_emif_byte_master.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/emif_byte_master.sv
// Purpose : serialises 1-4 byte read/write commands into EMIF byte cycles (memrd/memwr, memack), returns read data + timeout error, flags irq rising edges.
// Latency : accept at cycle 0, byte strobes at 1,3,..,2N-1 with immediate ack, rsp_valid_o at 2N; each unacked strobe cycle adds one cycle.
// Backpressure: cmd_ready_o low from accept until the response cycle has passed; rsp_valid_o is a one-cycle pulse with no backpressure.
//
// Ports:
//   clk_app_i, rst_clk_app_n           clock, synchronous active-low reset
//   cmd_valid_i/cmd_ready_o            command handshake; cmd_wr_i, cmd_addr_i, cmd_nbytes_i (count-1), cmd_wdata_i
//   rsp_valid_o, rsp_rdata_o, rsp_err_o completion pulse, read data (byte k at [8k+7:8k]), timeout flag
//   memaddr, memdatao, memrd, memwr    EMIF initiator outputs (address/data are 0 when no strobe is high)
//   memack, memdatai                   EMIF responder acknowledge and read data
//   irq, irq_rise_o                    responder interrupt level and its registered rising-edge pulse
module emif_byte_master #(
    parameter int ADDR_W  = 23,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_app_i,
    input  logic              rst_clk_app_n,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_wr_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [1:0]        cmd_nbytes_i,
    input  logic [31:0]       cmd_wdata_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o,
    output logic [ADDR_W-1:0] memaddr,
    output logic [7:0]        memdatao,
    output logic              memrd,
    output logic              memwr,
    input  logic              memack,
    input  logic [7:0]        memdatai,
    input  logic              irq,
    output logic              irq_rise_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        GAP    = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Count of unacked strobe cycles already seen; reaching TIMEOUT-1 with
    // another unacked cycle means the strobe has been high TIMEOUT cycles.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        nbytes_q, nbytes_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        k_q, k_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [31:0]       rdata_d;
    logic              err_d;
    logic              strobe_d;
    logic              irq_q;

    assign cmd_ready_o = (state_q == IDLE) && rst_clk_app_n;

    always_comb begin
        state_d  = state_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        nbytes_d = nbytes_q;
        wdata_d  = wdata_q;
        k_d      = k_q;
        cnt_d    = cnt_q;
        rdata_d  = rsp_rdata_o;
        err_d    = rsp_err_o;

        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    wr_d     = cmd_wr_i;
                    addr_d   = cmd_addr_i;
                    nbytes_d = cmd_nbytes_i;
                    wdata_d  = cmd_wdata_i;
                    k_d      = 2'd0;
                    cnt_d    = 8'd0;
                    rdata_d  = 32'd0;
                    err_d    = 1'b0;
                    state_d  = STROBE;
                end
            end
            STROBE: begin
                // An ack in the same cycle as the timeout completes the byte.
                if (memack) begin
                    if (!wr_q) begin
                        rdata_d[{k_q, 3'b000} +: 8] = memdatai;
                    end
                    if (k_q == nbytes_q) begin
                        state_d = RESP;
                    end else begin
                        k_d     = k_q + 2'd1;
                        state_d = GAP;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            GAP: begin
                cnt_d   = 8'd0;
                state_d = STROBE;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // EMIF outputs are registered from the next-state view so the strobe
    // appears in the cycle right after accept / gap.
    assign strobe_d = (state_d == STROBE);

    always_ff @(posedge clk_app_i) begin
        if (!rst_clk_app_n) begin
            state_q     <= IDLE;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            nbytes_q    <= 2'd0;
            wdata_q     <= 32'd0;
            k_q         <= 2'd0;
            cnt_q       <= 8'd0;
            rsp_rdata_o <= 32'd0;
            rsp_err_o   <= 1'b0;
            rsp_valid_o <= 1'b0;
            memrd       <= 1'b0;
            memwr       <= 1'b0;
            memaddr     <= '0;
            memdatao    <= 8'd0;
            irq_q       <= 1'b0;
            irq_rise_o  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            nbytes_q    <= nbytes_d;
            wdata_q     <= wdata_d;
            k_q         <= k_d;
            cnt_q       <= cnt_d;
            rsp_rdata_o <= rdata_d;
            rsp_err_o   <= err_d;
            rsp_valid_o <= (state_d == RESP);
            memrd       <= strobe_d && !wr_d;
            memwr       <= strobe_d && wr_d;
            memaddr     <= strobe_d ? (addr_d + ADDR_W'(k_d)) : '0;
            memdatao    <= strobe_d ? wdata_d[{k_d, 3'b000} +: 8] : 8'd0;
            irq_q       <= irq;
            irq_rise_o  <= irq && !irq_q;
        end
    end

endmodule

// File: tb/tb_emif_byte_master.sv
// Bench for emif_byte_master: table of directed commands, randomized commands
// against a per-byte timeline model, plus reset, stray-ack and irq sequences.
module tb_emif_byte_master;

    localparam int AW = 23;
    localparam int TO = 4;

    logic          clk_app_i = 1'b0;
    logic          rst_clk_app_n;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic          cmd_wr_i;
    logic [AW-1:0] cmd_addr_i;
    logic [1:0]    cmd_nbytes_i;
    logic [31:0]   cmd_wdata_i;
    logic          rsp_valid_o;
    logic [31:0]   rsp_rdata_o;
    logic          rsp_err_o;
    logic [AW-1:0] memaddr;
    logic [7:0]    memdatao;
    logic          memrd;
    logic          memwr;
    logic          memack;
    logic [7:0]    memdatai;
    logic          irq;
    logic          irq_rise_o;

    always #5 clk_app_i = ~clk_app_i;

    emif_byte_master #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk_app_i    (clk_app_i),
        .rst_clk_app_n(rst_clk_app_n),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_wr_i     (cmd_wr_i),
        .cmd_addr_i   (cmd_addr_i),
        .cmd_nbytes_i (cmd_nbytes_i),
        .cmd_wdata_i  (cmd_wdata_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_err_o    (rsp_err_o),
        .memaddr      (memaddr),
        .memdatao     (memdatao),
        .memrd        (memrd),
        .memwr        (memwr),
        .memack       (memack),
        .memdatai     (memdatai),
        .irq          (irq),
        .irq_rise_o   (irq_rise_o)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    // One expected bus cycle of the transaction timeline.
    typedef struct {
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [7:0]    dat;
        logic          ack;
        logic [7:0]    rdb;
        logic          gap;
        logic          rsp;
    } cyc_t;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [1:0]    nb;
        logic [31:0]   wdata;
        logic [31:0]   dly;     // byte j: unacked strobe cycles before ack (>=TO: never acked)
        logic [31:0]   rdv;     // responder read data, byte j at [8j+7:8j]
        logic          stray;   // pulse memack during gap cycles
        string         name;
        int            exp_cyc;
        logic [31:0]   exp_rdata;
        logic          exp_err;
    } vec_t;

    // Builds the expected timeline from the byte rules, then plays responder
    // and compares every cycle until the response cycle.
    task automatic do_cmd(input logic wr, input logic [AW-1:0] addr, input logic [1:0] nb,
                          input logic [31:0] wdata, input logic [31:0] dly, input logic [31:0] rdv,
                          input logic stray, input string name,
                          output int rsp_cyc, output logic [31:0] rdata_seen, output logic err_seen);
        cyc_t        q[$];
        cyc_t        e;
        logic [31:0] exp_rd;
        logic        exp_err;
        bit          stop;
        int          d;
        exp_rd  = 32'd0;
        exp_err = 1'b0;
        stop    = 1'b0;
        for (int j = 0; j <= int'(nb) && !stop; j++) begin
            e = '{default: '0};
            e.rd   = !wr;
            e.wr   = wr;
            e.addr = addr + AW'(j);
            e.dat  = wdata[8*j +: 8];
            e.rdb  = rdv[8*j +: 8];
            d      = int'(dly[8*j +: 8]);
            if (d < TO) begin
                for (int w = 0; w <= d; w++) begin
                    e.ack = (w == d);
                    q.push_back(e);
                end
                if (!wr) exp_rd[8*j +: 8] = rdv[8*j +: 8];
                if (j != int'(nb)) begin
                    e = '{default: '0};
                    e.gap = 1'b1;
                    q.push_back(e);
                end
            end else begin
                e.ack = 1'b0;
                for (int w = 0; w < TO; w++) q.push_back(e);
                exp_err = 1'b1;
                stop    = 1'b1;
            end
        end
        e = '{default: '0};
        e.rsp = 1'b1;
        q.push_back(e);

        @(negedge clk_app_i);
        chk({name, " ready_at_accept"}, 64'(cmd_ready_o), 64'(1));
        cmd_valid_i  = 1'b1;
        cmd_wr_i     = wr;
        cmd_addr_i   = addr;
        cmd_nbytes_i = nb;
        cmd_wdata_i  = wdata;
        memack       = 1'b0;
        rsp_cyc      = -1;
        rdata_seen   = 32'd0;
        err_seen     = 1'b0;
        for (int c = 1; c <= q.size(); c++) begin
            @(negedge clk_app_i);
            cmd_valid_i = 1'b0;
            e = q[c-1];
            chk($sformatf("%s cyc%0d {rdy,rd,wr,addr,dat,rsp}", name, c),
                64'({cmd_ready_o, memrd, memwr, memaddr, memdatao, rsp_valid_o}),
                64'({1'b0, e.rd, e.wr, e.addr, e.dat, e.rsp}));
            if (rsp_valid_o && rsp_cyc < 0) begin
                rsp_cyc    = c;
                rdata_seen = rsp_rdata_o;
                err_seen   = rsp_err_o;
            end
            if (e.rsp) begin
                chk({name, " err"}, 64'(rsp_err_o), 64'(exp_err));
                if (!wr) chk({name, " rdata"}, 64'(rsp_rdata_o), 64'(exp_rd));
            end
            memack   = e.ack || (e.gap && stray);
            memdatai = e.ack ? e.rdb : 8'hEE;
        end
        memack   = 1'b0;
        memdatai = 8'h00;
    endtask

    vec_t        vecs[7];
    int          rc;
    logic [31:0] rdv_seen;
    logic        err_seen;
    logic [AW-1:0] r_addr;
    logic [31:0] r_dly;
    logic [7:0]  irq_pat;
    int          rise_cnt;
    logic        exp_rise;

    initial begin
        vecs[0] = '{1'b0, 23'h040010, 2'd3, 32'h0000_0000, 32'h0000_0000, 32'h4433_2211, 1'b0, "rd4",   8,  32'h4433_2211, 1'b0};
        vecs[1] = '{1'b1, 23'h001234, 2'd1, 32'hCAFE_BEEF, 32'h0000_0303, 32'h0000_0000, 1'b0, "wr2",   10, 32'h0000_0000, 1'b0};
        vecs[2] = '{1'b0, 23'h000100, 2'd2, 32'h0000_0000, 32'h0000_FF00, 32'h00CC_BB5A, 1'b0, "tmo",   7,  32'h0000_005A, 1'b1};
        vecs[3] = '{1'b0, 23'h7FFFFF, 2'd1, 32'h0000_0000, 32'h0000_0000, 32'h0000_A55A, 1'b0, "wrap",  4,  32'h0000_A55A, 1'b0};
        vecs[4] = '{1'b0, 23'h000200, 2'd0, 32'h0000_0000, 32'h0000_0003, 32'h0000_0077, 1'b0, "coll",  5,  32'h0000_0077, 1'b0};
        vecs[5] = '{1'b1, 23'h000300, 2'd0, 32'h0000_0012, 32'h0000_00FF, 32'h0000_0000, 1'b0, "wrto",  5,  32'h0000_0000, 1'b1};
        vecs[6] = '{1'b0, 23'h000400, 2'd1, 32'h0000_0000, 32'h0000_0000, 32'h0000_9988, 1'b1, "stray", 4,  32'h0000_9988, 1'b0};

        rst_clk_app_n = 1'b0;
        cmd_valid_i   = 1'b0;
        cmd_wr_i      = 1'b0;
        cmd_addr_i    = '0;
        cmd_nbytes_i  = 2'd0;
        cmd_wdata_i   = 32'd0;
        memack        = 1'b0;
        memdatai      = 8'd0;
        irq           = 1'b0;

        // Reset state
        repeat (3) @(posedge clk_app_i);
        @(negedge clk_app_i);
        chk("reset outputs", 64'({cmd_ready_o, memrd, memwr, memaddr, memdatao, rsp_valid_o, rsp_err_o, irq_rise_o}), 64'(0));
        chk("reset rdata", 64'(rsp_rdata_o), 64'(0));
        rst_clk_app_n = 1'b1;
        @(negedge clk_app_i);
        chk("ready after reset", 64'(cmd_ready_o), 64'(1));

        // Directed table, issued back-to-back
        for (int i = 0; i < 7; i++) begin
            do_cmd(vecs[i].wr, vecs[i].addr, vecs[i].nb, vecs[i].wdata, vecs[i].dly, vecs[i].rdv,
                   vecs[i].stray, vecs[i].name, rc, rdv_seen, err_seen);
            chk({vecs[i].name, " rsp_cycle"}, 64'(rc), 64'(vecs[i].exp_cyc));
            chk({vecs[i].name, " rsp_err"}, 64'(err_seen), 64'(vecs[i].exp_err));
            if (!vecs[i].wr) chk({vecs[i].name, " rsp_rdata"}, 64'(rdv_seen), 64'(vecs[i].exp_rdata));
        end

        // Stray ack while idle: nothing starts, read data held
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_app_i);
            chk($sformatf("idle ack %0d {rd,wr,rsp,rdy}", i), 64'({memrd, memwr, rsp_valid_o, cmd_ready_o}), 64'(4'b0001));
            chk($sformatf("idle ack %0d rdata", i), 64'(rsp_rdata_o), 64'(vecs[6].exp_rdata));
            memack   = 1'b1;
            memdatai = 8'h33;
        end
        memack = 1'b0;

        // Randomized commands
        for (int n = 0; n < 30; n++) begin
            r_addr = ($urandom_range(0, 3) == 0) ? AW'(23'h7FFFFE + $urandom_range(0, 1)) : AW'($urandom);
            for (int j = 0; j < 4; j++)
                r_dly[8*j +: 8] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 6)) : 8'($urandom_range(0, 1));
            do_cmd(1'($urandom_range(0, 1)), r_addr, 2'($urandom_range(0, 3)), $urandom, r_dly, $urandom,
                   1'($urandom_range(0, 1)), $sformatf("rnd%0d", n), rc, rdv_seen, err_seen);
        end

        // Reset in the middle of a write
        @(negedge clk_app_i);
        cmd_valid_i  = 1'b1;
        cmd_wr_i     = 1'b1;
        cmd_addr_i   = 23'h000555;
        cmd_nbytes_i = 2'd3;
        cmd_wdata_i  = 32'h1234_5678;
        @(negedge clk_app_i);
        cmd_valid_i = 1'b0;
        chk("midrst strobe1", 64'(memwr), 64'(1));
        @(negedge clk_app_i);
        chk("midrst strobe2", 64'(memwr), 64'(1));
        rst_clk_app_n = 1'b0;
        @(posedge clk_app_i);
        #1;
        chk("midrst dropped {rd,wr,rsp,rdy}", 64'({memrd, memwr, rsp_valid_o, cmd_ready_o}), 64'(0));
        @(negedge clk_app_i);
        rst_clk_app_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_app_i);
            chk($sformatf("postrst %0d {rd,wr,rsp,rdy}", i), 64'({memrd, memwr, rsp_valid_o, cmd_ready_o}), 64'(4'b0001));
        end

        // irq 0->1->1->0->1->0: rise pulse one cycle after each 0->1
        irq_pat  = 8'b0001_0110;   // bit i is the level driven in step i
        rise_cnt = 0;
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk_app_i);
            if (i > 0) begin
                exp_rise = irq_pat[i-1] && !((i >= 2) ? irq_pat[i-2] : 1'b0);
                chk($sformatf("irq_rise step %0d", i), 64'(irq_rise_o), 64'(exp_rise));
                if (irq_rise_o) rise_cnt++;
            end
            irq = (i < 8) ? irq_pat[i] : 1'b0;
        end
        chk("irq_rise count", 64'(rise_cnt), 64'(2));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
